prog_fetch_ctrl: RTL
====================

# prog_fetch_ctrl

Instruction-fetch controller for the MIPS CPU. It owns the program counter and drives the 32-bit global address into the program-memory address decoder. It waits for the decoder's registered chip-select and the memory's synchronous read data, then presents each instruction to the decode stage through a valid/ready handshake. Out-of-range fetches (decoder deasserts chip-select) raise a sticky fault instead of delivering an instruction. Branch/jump redirects restart fetch at a new PC.

## Interface
- RESET_PC, 32'h31B0, PC loaded on reset; start of this group's program window.
- RD_LATENCY, 2, clock edges from the end of the ISSUE cycle to valid `instr_in` (decoder register plus memory read); legal range 1..7.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_addr  out  32  global fetch address, registered, to the decoder `address_in`.
- cs_p  in  1  active-low chip-select from the decoder: 0 = address inside the program window, 1 = outside.
- instr_in  in  32  program-memory read data.
- redirect_valid  in  1  one-cycle request to restart fetch at `redirect_pc`.
- redirect_pc  in  32  new PC; bits [1:0] are forced to 0.
- instr_valid  out  1  `instr_out` and `instr_pc` hold a fetched instruction.
- instr_ready  in  1  decode stage accepts; transfer occurs when `instr_valid & instr_ready`.
- instr_out  out  32  fetched instruction word.
- instr_pc  out  32  global address of `instr_out`.
- fault  out  1  sticky fetch-fault flag.
- fault_pc  out  32  address that caused the fault.

## Operation
- State machine: ISSUE, WAIT, HOLD, FAULT. Internal `pc` register (32 bits) and wait counter `cnt` (3 bits).
- Reset (async): state=ISSUE, pc=fetch_addr=RESET_PC, cnt=0, instr_valid=0, instr_out=0, instr_pc=0, fault=0, fault_pc=0.
- ISSUE (1 cycle): `fetch_addr` already equals `pc`. Next state WAIT, cnt=0.
- WAIT: `fetch_addr` is held constant, so the decoder outputs stay stable. cnt increments each cycle. In the cycle where cnt==RD_LATENCY-1, sample `cs_p` and `instr_in` together:
  - cs_p==0: instr_out<=instr_in, instr_pc<=pc, instr_valid<=1; go to HOLD.
  - cs_p==1: fault<=1, fault_pc<=pc, instr_valid stays 0; go to FAULT.
- `cs_p` is ignored in every cycle other than the capture cycle.
- HOLD: instr_valid=1, and `instr_out`/`instr_pc` are held stable until the handshake. On `instr_ready`: instr_valid<=0, pc<=pc+4, fetch_addr<=pc+4, go to ISSUE.
- FAULT: no fetch activity; `fetch_addr` is held at the faulting address. The state is left only by redirect or reset.
- Redirect (highest priority, any state): pc<=fetch_addr<={redirect_pc[31:2],2'b00}, cnt<=0, instr_valid<=0, fault<=0, go to ISSUE.
  - Any in-flight read data is discarded.
  - `fault_pc` keeps its last value.
- Redirect and `instr_ready` in the same HOLD cycle: the held instruction counts as transferred, and the next PC is the redirect target, not pc+4.
- PC arithmetic is modulo 2^32: pc+4 from 32'hFFFFFFFC wraps to 0. The block does no range check of its own; the window is enforced only through `cs_p`.

## Timing
- Single outstanding fetch. Minimum cycles per instruction = 1 (ISSUE) + RD_LATENCY (WAIT) + 1 (HOLD) = 4 at default.
- Reset release edge to first `instr_valid`=1 is RD_LATENCY+1 edges, i.e. 3 at default.
- Handshake edge to new `fetch_addr` is 0 cycles: it updates on the same edge instr_valid falls.
- Redirect edge to `fetch_addr`=target is the same edge. The first instruction from the target is valid RD_LATENCY+1 edges later.
- `fault` rises on the capture edge, the same edge at which `instr_valid` would have risen.
- Outputs change only on clk edges or on async reset assertion.

## Test plan
- Reset: hold rst=1 → fetch_addr=32'h31B0, instr_valid=0, fault=0. Release rst → instr_valid=1 on the 3rd edge with instr_pc=32'h31B0 and instr_out = memory word 0.
- Streaming with instr_ready=1 → instr_pc sequence 32'h31B0, 32'h31B4, 32'h31B8, each instr_valid pulse 1 cycle wide, spaced 4 cycles apart.
- Backpressure with instr_ready=0 for 6 cycles in HOLD → instr_valid, instr_out and instr_pc stable, fetch_addr stays 32'h31B0. Raising ready → fetch_addr=32'h31B4 on the next edge.
- Window end: redirect to 32'h35AC, accept it, next fetch 32'h35B0 → cs_p=1 → fault=1, fault_pc=32'h35B0, instr_valid never asserts, fetch_addr remains 32'h35B0.
- Redirect in WAIT to 32'h3203 → fetch_addr=32'h3200 on the same edge, the stale word is never presented, and the next instr_pc=32'h3200. A redirect while in FAULT clears fault on that edge.
- Async rst asserted mid-WAIT and mid-HOLD → all outputs reach reset values before the next clk edge, and fetch restarts at 32'h31B0.

Source files
------------

// File: rtl/prog_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one fetch at a time to the
// program-memory decoder and hands each instruction to decode via valid/ready.
module prog_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_31B0,
    parameter int          RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] fetch_addr,
    input  logic        cs_p,
    input  logic [31:0] instr_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [2:0] CAP_CNT = 3'(RD_LATENCY - 1);

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [2:0]  cnt_r, cnt_s;
    logic        valid_r, valid_s;
    logic [31:0] instr_r, instr_s;
    logic [31:0] ipc_r, ipc_s;
    logic        fault_r, fault_s;
    logic [31:0] fault_pc_r, fault_pc_s;

    // The PC register doubles as the registered fetch address, so they can never diverge.
    assign fetch_addr  = pc_r;
    assign instr_valid = valid_r;
    assign instr_out   = instr_r;
    assign instr_pc    = ipc_r;
    assign fault       = fault_r;
    assign fault_pc    = fault_pc_r;

    // Next-state and next-output logic; redirect overrides every state.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        cnt_s      = cnt_r;
        valid_s    = valid_r;
        instr_s    = instr_r;
        ipc_s      = ipc_r;
        fault_s    = fault_r;
        fault_pc_s = fault_pc_r;
        if (redirect_valid) begin
            pc_s    = {redirect_pc[31:2], 2'b00};
            cnt_s   = 3'd0;
            valid_s = 1'b0;
            fault_s = 1'b0;
            state_s = ST_ISSUE;
        end else begin
            case (state_r)
                ST_ISSUE: begin
                    cnt_s   = 3'd0;
                    state_s = ST_WAIT;
                end
                ST_WAIT: begin
                    // cs_p and read data are only meaningful in the capture cycle.
                    if (cnt_r == CAP_CNT) begin
                        if (!cs_p) begin
                            instr_s = instr_in;
                            ipc_s   = pc_r;
                            valid_s = 1'b1;
                            state_s = ST_HOLD;
                        end else begin
                            fault_s    = 1'b1;
                            fault_pc_s = pc_r;
                            state_s    = ST_FAULT;
                        end
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        valid_s = 1'b0;
                        pc_s    = pc_r + 32'd4;
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_FAULT: begin
                    state_s = ST_FAULT;
                end
                default: begin
                    state_s = ST_ISSUE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_ISSUE;
            pc_r       <= RESET_PC;
            cnt_r      <= 3'd0;
            valid_r    <= 1'b0;
            instr_r    <= 32'd0;
            ipc_r      <= 32'd0;
            fault_r    <= 1'b0;
            fault_pc_r <= 32'd0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            cnt_r      <= cnt_s;
            valid_r    <= valid_s;
            instr_r    <= instr_s;
            ipc_r      <= ipc_s;
            fault_r    <= fault_s;
            fault_pc_r <= fault_pc_s;
        end
    end

endmodule
